// File: rtl/xw_pipeline_reg.sv
// X-to-W pipeline register with W-to-X forwarding detect
// and free-running cycle / retired-instruction counters.
module xw_pipeline_reg #(
  parameter int         DWIDTH     = 32,
  parameter logic [1:0] WB_SEL_RST = 2'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_x,
  input  logic              reg_we_x,
  input  logic [1:0]        wb_sel_x,
  input  logic [4:0]        rd_x,
  input  logic [4:0]        rs1_x,
  input  logic [4:0]        rs2_x,
  input  logic [DWIDTH-1:0] alu_out_x,
  input  logic [DWIDTH-1:0] pc_x,
  output logic              valid_w,
  output logic              reg_we_w,
  output logic [1:0]        wb_sel_w,
  output logic [4:0]        rd_w,
  output logic [DWIDTH-1:0] alu_out_w,
  output logic [DWIDTH-1:0] pc4_w,
  output logic              fwd_a_o,
  output logic              fwd_b_o,
  input  logic              cnt_clr_i,
  output logic [DWIDTH-1:0] cycle_cnt_o,
  output logic [DWIDTH-1:0] instret_cnt_o
);

  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic [1:0]        sel_q, sel_d;
  logic [4:0]        rd_q, rd_d;
  logic [DWIDTH-1:0] alu_q, alu_d;
  logic [DWIDTH-1:0] pc4_q, pc4_d;
  logic [DWIDTH-1:0] cyc_q, cyc_d;
  logic [DWIDTH-1:0] ret_q, ret_d;
  logic              w_live;

  // W-stage next state: flush beats stall, stall holds
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    alu_d   = alu_q;
    pc4_d   = pc4_q;
    if (flush_i) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      sel_d   = WB_SEL_RST;
      rd_d    = '0;
      alu_d   = '0;
      pc4_d   = '0;
    end else if (!stall_i) begin
      valid_d = valid_x;
      we_d    = valid_x & reg_we_x;
      sel_d   = wb_sel_x;
      rd_d    = rd_x;
      alu_d   = alu_out_x;
      pc4_d   = pc_x + DWIDTH'(4);
    end
  end

  // Counter next state: clear overrides any increment
  always_comb begin
    cyc_d = cyc_q + DWIDTH'(1);
    ret_d = ret_q;
    if (valid_q && !stall_i) begin
      ret_d = ret_q + DWIDTH'(1);
    end
    if (cnt_clr_i) begin
      cyc_d = '0;
      ret_d = '0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= WB_SEL_RST;
      rd_q    <= '0;
      alu_q   <= '0;
      pc4_q   <= '0;
      cyc_q   <= '0;
      ret_q   <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      pc4_q   <= pc4_d;
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
    end
  end

  // x0 never forwards; a bubble never forwards
  assign w_live  = valid_q & we_q & (rd_q != 5'd0);
  assign fwd_a_o = w_live & (rd_q == rs1_x);
  assign fwd_b_o = w_live & (rd_q == rs2_x);

  assign valid_w       = valid_q;
  assign reg_we_w      = we_q;
  assign wb_sel_w      = sel_q;
  assign rd_w          = rd_q;
  assign alu_out_w     = alu_q;
  assign pc4_w         = pc4_q;
  assign cycle_cnt_o   = cyc_q;
  assign instret_cnt_o = ret_q;

endmodule
